// File: rtl/serial_out_defs_pkg.sv
// Shared encodings for the programmable serial pattern generator.
package serial_out_defs;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        IDLE_LOW    = 2'b00,
        IDLE_HIGH   = 2'b01,
        IDLE_KEEP   = 2'b10,
        IDLE_REPEAT = 2'b11
    } idle_mode_t;

endpackage

// File: rtl/prog_tick_gen.sv
// Programmable mod-(div+1) tick generator; held at zero while cleared.
module prog_tick_gen #(
    parameter int DIV_BIT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clr,
    input  logic [DIV_BIT-1:0] i_div,
    output logic               o_tick
);

    logic [DIV_BIT-1:0] count;

    assign o_tick = !i_clr && (count == i_div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (i_clr || o_tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/multi_freq_serial_out.sv
// Serial pattern generator: shifts a latched word out at a programmable bit rate,
// with programmable frame length, bit order and post-frame idle behaviour.
module multi_freq_serial_out
    import serial_out_defs::*;
#(
    parameter int DATA_BIT     = 32,
    parameter int TICK_PER_BIT = 16,
    parameter int DIV_BIT      = 8,
    parameter int LEN_BIT      = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [DIV_BIT-1:0]  i_div,
    input  logic [LEN_BIT-1:0]  i_len,
    input  logic                i_lsb_first,
    input  logic [1:0]          i_idle_mode,
    input  logic [DATA_BIT-1:0] i_data,
    output logic                o_data,
    output logic                o_busy,
    output logic                o_done_tick
);

    localparam int TPB_BIT = $clog2(TICK_PER_BIT + 1);
    localparam logic [TPB_BIT-1:0] TPB_LAST = TPB_BIT'(TICK_PER_BIT - 1);
    localparam logic [LEN_BIT-1:0] LEN_MAX  = LEN_BIT'(DATA_BIT);

    state_t              state;
    idle_mode_t          mode_q;
    logic [DIV_BIT-1:0]  div_q;
    logic [LEN_BIT-1:0]  len_q;
    logic [LEN_BIT-1:0]  bit_idx;
    logic [LEN_BIT-1:0]  start_len;
    logic                lsb_q;
    logic [DATA_BIT-1:0] data_q;
    logic [TPB_BIT-1:0]  tick_cnt;
    logic                tick;
    logic                div_clr;

    // Position of frame bit idx inside the data word for the chosen order.
    function automatic logic pick_bit(
        input logic [DATA_BIT-1:0] data,
        input logic [LEN_BIT-1:0]  idx,
        input logic [LEN_BIT-1:0]  len,
        input logic                lsb
    );
        logic [LEN_BIT-1:0]  pos;
        logic [DATA_BIT-1:0] shifted;
        pos     = lsb ? idx : LEN_BIT'(len - idx - 1'b1);
        shifted = data >> pos;
        return shifted[0];
    endfunction

    always_comb begin
        start_len = i_len;
        if (i_len == '0 || i_len > LEN_MAX) begin
            start_len = LEN_MAX;
        end
    end

    assign div_clr = (state == ST_IDLE) || i_stop;

    prog_tick_gen #(.DIV_BIT(DIV_BIT)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (div_clr),
        .i_div (div_q),
        .o_tick(tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            mode_q      <= IDLE_LOW;
            div_q       <= '0;
            len_q       <= '0;
            lsb_q       <= 1'b0;
            data_q      <= '0;
            bit_idx     <= '0;
            tick_cnt    <= '0;
            o_data      <= 1'b0;
            o_busy      <= 1'b0;
            o_done_tick <= 1'b0;
        end else begin
            o_done_tick <= 1'b0;
            if (i_stop) begin
                state    <= ST_IDLE;
                o_data   <= 1'b0;
                o_busy   <= 1'b0;
                bit_idx  <= '0;
                tick_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_start) begin
                            mode_q   <= idle_mode_t'(i_idle_mode);
                            div_q    <= i_div;
                            len_q    <= start_len;
                            lsb_q    <= i_lsb_first;
                            data_q   <= i_data;
                            bit_idx  <= '0;
                            tick_cnt <= '0;
                            o_data   <= pick_bit(i_data, '0, start_len, i_lsb_first);
                            o_busy   <= 1'b1;
                            state    <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (tick) begin
                            if (tick_cnt != TPB_LAST) begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end else begin
                                tick_cnt <= '0;
                                if (bit_idx != LEN_BIT'(len_q - 1'b1)) begin
                                    bit_idx <= bit_idx + 1'b1;
                                    o_data  <= pick_bit(data_q, LEN_BIT'(bit_idx + 1'b1), len_q, lsb_q);
                                end else begin
                                    // Frame end: the post-frame level appears in the done clk.
                                    bit_idx     <= '0;
                                    o_done_tick <= 1'b1;
                                    case (mode_q)
                                        IDLE_LOW:    o_data <= 1'b0;
                                        IDLE_HIGH:   o_data <= 1'b1;
                                        IDLE_KEEP:   o_data <= o_data;
                                        IDLE_REPEAT: o_data <= pick_bit(data_q, '0, len_q, lsb_q);
                                    endcase
                                    if (mode_q != IDLE_REPEAT) begin
                                        state  <= ST_IDLE;
                                        o_busy <= 1'b0;
                                    end
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multi_freq_serial_out.sv
// Run-length scoreboard bench for multi_freq_serial_out.
module tb_multi_freq_serial_out;

    localparam int DATA_BIT = 32;
    localparam int DIV_BIT  = 8;
    localparam int LEN_BIT  = 6;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                i_start = 1'b0;
    logic                i_stop = 1'b0;
    logic [DIV_BIT-1:0]  i_div = '0;
    logic [LEN_BIT-1:0]  i_len = '0;
    logic                i_lsb_first = 1'b0;
    logic [1:0]          i_idle_mode = '0;
    logic [DATA_BIT-1:0] i_data = '0;
    logic                o_data;
    logic                o_busy;
    logic                o_done_tick;

    // One expected run: output level {data,busy,done} held for len clks (0 = any length).
    typedef struct {
        logic        d;
        logic        b;
        logic        dn;
        int unsigned len;
    } run_t;

    run_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned run_no = 0;
    logic        mon_en = 1'b0;
    logic [2:0]  prev = '0;
    int unsigned run_len = 0;

    always #5 clk = ~clk;

    multi_freq_serial_out #(
        .DATA_BIT    (DATA_BIT),
        .TICK_PER_BIT(16),
        .DIV_BIT     (DIV_BIT),
        .LEN_BIT     (LEN_BIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_div      (i_div),
        .i_len      (i_len),
        .i_lsb_first(i_lsb_first),
        .i_idle_mode(i_idle_mode),
        .i_data     (i_data),
        .o_data     (o_data),
        .o_busy     (o_busy),
        .o_done_tick(o_done_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic d, input logic b, input logic dn, input int unsigned len);
        run_t r;
        r.d = d;
        r.b = b;
        r.dn = dn;
        r.len = len;
        exp_q.push_back(r);
    endtask

    task automatic check_run(input logic [2:0] obs, input int unsigned len);
        run_t e;
        run_no++;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL run%0d_unexpected: got data/busy/done=%b for %0d clks, required no further runs",
                     run_no, obs, len);
            return;
        end
        e = exp_q.pop_front();
        check($sformatf("run%0d_level", run_no), {29'b0, obs}, {29'b0, e.d, e.b, e.dn});
        if (e.len != 0) check($sformatf("run%0d_len", run_no), len, e.len);
    endtask

    // Monitor: compresses the output into runs and checks each completed run.
    always @(negedge clk) begin
        if (mon_en) begin
            if ({o_data, o_busy, o_done_tick} == prev) begin
                run_len++;
            end else begin
                check_run(prev, run_len);
                prev = {o_data, o_busy, o_done_tick};
                run_len = 1;
            end
        end
    end

    task automatic start_frame(input logic [DIV_BIT-1:0] div, input logic [LEN_BIT-1:0] len,
                               input logic [DATA_BIT-1:0] data, input logic lsb, input logic [1:0] mode);
        @(negedge clk);
        i_div = div;
        i_len = len;
        i_data = data;
        i_lsb_first = lsb;
        i_idle_mode = mode;
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        i_div = ~div;
        i_len = ~len;
        i_data = ~data;
        i_lsb_first = ~lsb;
        i_idle_mode = ~mode;
    endtask

    task automatic push_t2();
        push(1, 1, 0, 32); push(0, 1, 0, 32); push(1, 0, 1, 1); push(1, 0, 0, 0);
    endtask

    task automatic push_t3();
        push(1, 1, 0, 16); push(0, 1, 0, 32); push(0, 0, 1, 1); push(0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", {31'b0, o_data}, 32'd0);
        check("reset_busy", {31'b0, o_busy}, 32'd0);
        check("reset_done", {31'b0, o_done_tick}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev = {o_data, o_busy, o_done_tick};
        run_len = 0;
        mon_en = 1'b1;
        push(0, 0, 0, 0);

        // 8'hA5, MSB first, div 3: 64-clk bits, idle low
        push(1, 1, 0, 64); push(0, 1, 0, 64); push(1, 1, 0, 64); push(0, 1, 0, 128);
        push(1, 1, 0, 64); push(0, 1, 0, 64); push(1, 1, 0, 64); push(0, 0, 1, 1); push(0, 0, 0, 0);
        start_frame(8'd3, 6'd8, 32'h0000_00A5, 1'b0, 2'b00);
        repeat (540) @(posedge clk);

        // 4'b0011, LSB first, div 0, idle high
        push_t2();
        start_frame(8'd0, 6'd4, 32'h0000_0003, 1'b1, 2'b01);
        repeat (90) @(posedge clk);

        // keep-last mode: 3'b100 MSB first, then 3'b001 LSB first
        push_t3();
        start_frame(8'd0, 6'd3, 32'h0000_0004, 1'b0, 2'b10);
        repeat (70) @(posedge clk);
        push_t3();
        start_frame(8'd0, 6'd3, 32'h0000_0001, 1'b1, 2'b10);
        repeat (70) @(posedge clk);

        // repeat mode, 2'b10 MSB first, div 1; stop 11 clks into the third frame
        push(1, 1, 0, 32); push(0, 1, 0, 32); push(1, 1, 1, 1); push(1, 1, 0, 31);
        push(0, 1, 0, 32); push(1, 1, 1, 1); push(1, 1, 0, 11); push(0, 0, 0, 0);
        start_frame(8'd1, 6'd2, 32'h0000_0002, 1'b0, 2'b11);
        repeat (139) @(posedge clk);
        @(negedge clk);
        i_stop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_stop = 1'b0;
        repeat (20) @(posedge clk);

        // start together with stop starts nothing
        @(negedge clk);
        i_div = '0;
        i_len = 6'd4;
        i_data = 32'hFFFF_FFFF;
        i_start = 1'b1;
        i_stop = 1'b1;
        @(posedge clk);
        #1;
        check("start_stop_busy", {31'b0, o_busy}, 32'd0);
        @(negedge clk);
        i_start = 1'b0;
        i_stop = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("start_stop_idle", {30'b0, o_busy, o_data}, 32'd0);

        // len 0 -> 32 bits; a mid-frame start with new inputs must not disturb it
        push(1, 1, 0, 64); push(0, 1, 0, 64); push(1, 1, 0, 64); push(0, 1, 0, 192);
        push(1, 1, 0, 128); push(0, 0, 1, 1); push(0, 0, 0, 0);
        start_frame(8'd0, 6'd0, 32'hF0F0_00FF, 1'b0, 2'b00);
        repeat (100) @(negedge clk);
        i_start = 1'b1;
        i_data = 32'h0;
        i_len = 6'd1;
        i_div = 8'd5;
        i_idle_mode = 2'b11;
        @(negedge clk);
        i_start = 1'b0;
        repeat (450) @(posedge clk);

        // async reset mid-frame, then a clean frame
        push(1, 1, 0, 20); push(0, 0, 0, 0);
        start_frame(8'd0, 6'd4, 32'h0000_0003, 1'b1, 2'b01);
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_data", {31'b0, o_data}, 32'd0);
        check("async_rst_busy", {31'b0, o_busy}, 32'd0);
        check("async_rst_done", {31'b0, o_done_tick}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        push_t2();
        start_frame(8'd0, 6'd4, 32'h0000_0003, 1'b1, 2'b01);
        repeat (90) @(posedge clk);

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check_run(prev, run_len);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
